neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter N_INPUTS, default 4: number of input/weight pairs summed per neuron evaluation (2..16).
REQ-002 Parameter ACC_W, default 20: accumulator width in bits.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 start  input  1: begin one neuron evaluation; sampled only in IDLE.
REQ-006 x_data  input  8 signed: activation input, Q4.4.
REQ-007 x_valid  input  1: x_data valid.
REQ-008 x_ready  output  1: block accepts x_data this cycle.
REQ-009 w_addr  output  clog2(N_INPUTS): index of the weight needed for the current x_data.
REQ-010 w_data  input  8 signed: weight at w_addr, combinational same-cycle read, Q4.4.
REQ-011 bias  input  8 signed: neuron bias, Q4.4, sampled when start is accepted.
REQ-012 z__value  output  8 signed: pre-activation sum, Q4.4; feeds the sigmoid LUT/interpolator stage (address = bits 7:4, remainder = bits 3:0).
REQ-013 z_valid  output  1: z__value valid.
REQ-014 z_ready  input  1: downstream accepts z__value.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, ROUND, OUT.
REQ-016 IDLE: start=1 -> load acc = sign-extended bias << 4; count = 0; go to ACCUM.
REQ-017 ACCUM: x_ready=1; w_addr = count; a beat is accepted when x_valid & x_ready.
REQ-018 Each accepted beat: acc += sign-extended 16-bit product x_data*w_data (Q8.8); count += 1.
REQ-019 x_valid=0 in ACCUM: acc and count hold; no timeout.
REQ-020 Beat with count = N_INPUTS-1: accumulated, then go to ROUND; count returns to 0 (no wrap past N_INPUTS-1).
REQ-021 ROUND (1 cycle): r = (acc + 8) >>> 4 (round half up, arithmetic shift); saturate r to [-128, 127]; register into z__value; go to OUT.
REQ-022 OUT: z_valid=1, z__value stable until z_valid & z_ready; on handshake go to IDLE.
REQ-023 Latency: z_valid SHALL assert exactly 2 cycles after the clock edge accepting the last beat.
REQ-024 start outside IDLE SHALL be ignored; start and handshake in the same OUT cycle starts nothing (start re-sampled next cycle in IDLE).
REQ-025 x_ready SHALL be 0 in IDLE, ROUND, OUT; z_valid SHALL be 0 outside OUT.
REQ-026 ACC_W SHALL hold N_INPUTS full-scale products plus bias without overflow for the default parameters.

Reset
REQ-027 rst=1 at any clock edge, including mid-ACCUM or in OUT: state=IDLE, acc=0, count=0, z__value=0, z_valid=0, x_ready=0, w_addr=0.
REQ-028 A pending output not yet accepted at reset SHALL be discarded.

Structure
REQ-029 Shared package SHALL hold: Q4.4 fixed-point width (8) and fraction bits (4), saturation limits (127, -128), FSM state enumeration.
REQ-030 One sub-module neuron_mac_round_sat (combinational round-and-saturate, ACC_W in, 8 out) SHALL be used; the rest is flat.

Verification
REQ-031 bias=0, x={16,16,16,16}, w={16,16,16,16} -> z__value=64 (4.0).
REQ-032 bias=16, x={0,0,0,0} -> z__value=16.
REQ-033 bias=0, x={1,0,0,0}, w all 8 -> acc=8, rounds to z__value=1; x={1,0,0,0}, w all 7 -> z__value=0.
REQ-034 x all 127, w all 127 -> z__value=127 (saturate high); x all -128, w all 127 -> z__value=-128 (saturate low).
REQ-035 x_valid toggled randomly, z_ready held low 5 cycles -> same z__value as ungapped run, held stable, z_valid high all 5 cycles, single handshake.
REQ-036 rst pulsed after 2 of 4 beats -> outputs at reset values next cycle; following start with REQ-031 stimulus -> z__value=64.

Source files
------------

// File: rtl/neuron_mac_pkg.sv
// neuron_mac_pkg: shared Q4.4 fixed-point constants and FSM state encoding
// for the neuron_mac block and its round/saturate stage.
package neuron_mac_pkg;
   localparam int Q_W     = 8;
   localparam int Q_FRAC  = 4;
   localparam int SAT_MAX = 127;
   localparam int SAT_MIN = -128;
   typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_e;
endpackage

// File: rtl/neuron_mac_round_sat.sv
// neuron_mac_round_sat: converts a Q8.8 accumulator to Q4.4 with
// round-half-up and saturation to the signed 8-bit range.
//   acc_i : signed accumulator, ACC_W bits, Q8.8
//   z_o   : signed Q4.4 result
module neuron_mac_round_sat
   import neuron_mac_pkg::*;
#(
   parameter int ACC_W = 20
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic signed [Q_W-1:0]   z_o
);
   localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(SAT_MAX);
   localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(SAT_MIN);
   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] r;
   // one guard bit so adding the half-LSB can never wrap
   assign sum = {acc_i[ACC_W-1], acc_i} + (ACC_W+1)'(1 << (Q_FRAC-1));
   assign r   = sum >>> Q_FRAC;
   assign z_o = r > HI ? Q_W'(SAT_MAX) : r < LO ? Q_W'(SAT_MIN) : r[Q_W-1:0];
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: one neuron pre-activation z = bias + sum(x[i]*w[i]) in Q4.4.
//   clk, rst      : clock, synchronous active-high reset
//   start, bias   : begin an evaluation (IDLE only), bias sampled then
//   x_data/x_valid/x_ready : activation stream, one beat per input
//   w_addr/w_data : weight index for the current beat, same-cycle weight
//   z__value/z_valid/z_ready : rounded, saturated result handshake
module neuron_mac
   import neuron_mac_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int ACC_W    = 20
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic signed [Q_W-1:0]       x_data,
   input  logic                        x_valid,
   output logic                        x_ready,
   output logic [$clog2(N_INPUTS)-1:0] w_addr,
   input  logic signed [Q_W-1:0]       w_data,
   input  logic signed [Q_W-1:0]       bias,
   output logic signed [Q_W-1:0]       z__value,
   output logic                        z_valid,
   input  logic                        z_ready
);
   localparam int CW = $clog2(N_INPUTS);
   state_e                  state_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [CW-1:0]           cnt_q;
   logic signed [Q_W-1:0]   z_q;
   logic                    x_ready_q;
   logic                    z_valid_q;
   logic signed [2*Q_W-1:0] prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [Q_W-1:0]   z_rs;
   logic                    last;
   assign prod     = x_data * w_data;
   assign prod_ext = prod;
   assign bias_ext = bias;
   assign acc_d    = acc_q + prod_ext;
   assign last     = cnt_q == CW'(N_INPUTS-1);
   neuron_mac_round_sat #(.ACC_W(ACC_W)) u_round_sat (
      .acc_i (acc_q),
      .z_o   (z_rs)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         z_q       <= '0;
         x_ready_q <= 1'b0;
         z_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               // bias is Q4.4; shift aligns it to the Q8.8 product scale
               acc_q     <= bias_ext <<< Q_FRAC;
               cnt_q     <= '0;
               x_ready_q <= 1'b1;
               state_q   <= ACCUM;
            end
            ACCUM: if (x_valid && x_ready_q) begin
               acc_q <= acc_d;
               if (last) begin
                  cnt_q     <= '0;
                  x_ready_q <= 1'b0;
                  state_q   <= ROUND;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ROUND: begin
               z_q       <= z_rs;
               z_valid_q <= 1'b1;
               state_q   <= OUT;
            end
            OUT: if (z_ready) begin
               z_valid_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign x_ready  = x_ready_q;
   assign z_valid  = z_valid_q;
   assign z__value = z_q;
   assign w_addr   = cnt_q;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: scoreboard bench for neuron_mac with directed vectors.
module tb_neuron_mac;
   logic              clk = 1'b0;
   logic              rst, start, x_valid, z_ready, z_valid, x_ready;
   logic signed [7:0] x_data, bias, w_data, z__value;
   logic [1:0]        w_addr;
   logic signed [7:0] w_mem [4];
   int                sb[$];
   int                errors = 0, checks = 0, pushes = 0, handshakes = 0;

   always #5 clk = ~clk;
   assign w_data = w_mem[w_addr];

   neuron_mac dut (
      .clk(clk), .rst(rst), .start(start), .x_data(x_data), .x_valid(x_valid),
      .x_ready(x_ready), .w_addr(w_addr), .w_data(w_data), .bias(bias),
      .z__value(z__value), .z_valid(z_valid), .z_ready(z_ready)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compare every output handshake against the scoreboard head
   always @(negedge clk) begin
      #2;
      if (!rst && z_valid && z_ready) begin
         handshakes++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got z=%0d expected no output", int'(z__value));
         end else begin
            chk("z_value", int'(z__value), sb.pop_front());
         end
      end
   end

   // mode 0: plain; 1: random x gaps + 5-cycle z stall with start held;
   // 2: reset while the result is pending (result discarded, not pushed)
   task automatic run(input logic signed [7:0] b, input logic [31:0] xs,
                      input logic [31:0] ws, input int expz, input int mode);
      for (int i = 0; i < 4; i++) w_mem[i] = ws[8*i +: 8];
      if (mode != 2) begin
         sb.push_back(expz);
         pushes++;
      end
      z_ready = (mode == 0);
      @(negedge clk);
      start = 1'b1;
      bias  = b;
      @(negedge clk);
      start = 1'b0;
      bias  = 8'sd0;
      for (int i = 0; i < 4; i++) begin
         if (mode == 1) begin
            repeat ($urandom_range(0, 3)) begin
               x_valid = 1'b0;
               x_data  = 8'sh55;
               @(negedge clk);
            end
         end
         chk("x_ready_accum", int'(x_ready), 1);
         chk("w_addr", int'(w_addr), i);
         x_data  = xs[8*i +: 8];
         x_valid = 1'b1;
         @(negedge clk);
      end
      x_valid = 1'b0;
      chk("round_no_valid", int'(z_valid), 0);
      chk("round_no_ready", int'(x_ready), 0);
      @(negedge clk);
      chk("latency_valid", int'(z_valid), 1);
      if (mode == 1) begin
         start = 1'b1;
         for (int c = 0; c < 5; c++) begin
            chk("stall_valid", int'(z_valid), 1);
            chk("stall_value", int'(z__value), expz);
            chk("stall_no_ready", int'(x_ready), 0);
            @(negedge clk);
         end
         z_ready = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("post_hs_valid", int'(z_valid), 0);
         chk("post_hs_no_start", int'(x_ready), 0);
      end else if (mode == 2) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("rst_out_valid", int'(z_valid), 0);
         chk("rst_out_value", int'(z__value), 0);
         z_ready = 1'b1;
         @(negedge clk);
         chk("rst_out_stays_idle", int'(z_valid), 0);
      end else begin
         @(negedge clk);
         chk("post_hs_valid", int'(z_valid), 0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = '0; bias = '0; z_ready = 1'b1;
      for (int i = 0; i < 4; i++) w_mem[i] = '0;
      repeat (2) @(negedge clk);
      chk("rst_x_ready", int'(x_ready), 0);
      chk("rst_z_valid", int'(z_valid), 0);
      chk("rst_w_addr", int'(w_addr), 0);
      chk("rst_z_value", int'(z__value), 0);
      rst = 1'b0;
      run(8'sd0,   32'h10101010, 32'h10101010,   64, 0);
      run(8'sd16,  32'h00000000, 32'h10101010,   16, 0);
      run(8'sd0,   32'h00000001, 32'h08080808,    1, 0);
      run(8'sd0,   32'h00000001, 32'h07070707,    0, 0);
      run(8'sd0,   32'h7f7f7f7f, 32'h7f7f7f7f,  127, 0);
      run(8'sd0,   32'h80808080, 32'h7f7f7f7f, -128, 0);
      run(-8'sd16, 32'h20202020, 32'hf8f8f8f8,  -80, 0);
      run(8'sd0,   32'h04030201, 32'h40302010,   30, 0);
      run(8'sd0,   32'h10101010, 32'h10101010,   64, 1);
      // reset after two of four beats: partial sum must be dropped
      for (int i = 0; i < 4; i++) w_mem[i] = 8'sd16;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) begin x_data = 8'sd16; x_valid = 1'b1; @(negedge clk); end
      x_valid = 1'b0;
      chk("mid_w_addr", int'(w_addr), 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_x_ready", int'(x_ready), 0);
      chk("mid_rst_z_valid", int'(z_valid), 0);
      chk("mid_rst_w_addr", int'(w_addr), 0);
      chk("mid_rst_z_value", int'(z__value), 0);
      run(8'sd0,  32'h10101010, 32'h10101010, 64, 0);
      run(8'sd0,  32'h10101010, 32'h10101010, 64, 2);
      run(8'sd16, 32'h00000000, 32'h00000000, 16, 0);
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("handshake_count", handshakes, pushes);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end
endmodule
